// File: rtl/wire_trigger_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// wirelog_sched_pkg
//   Shared types and helpers for the wire trigger scheduler.
//   - sched_state_e : frame FSM states (IDLE, LAUNCH, SETTLE, RESET)
//   - clog2_min1    : $clog2 that never returns less than 1 (usable as a width)
//   - CNT_W         : settle counter width for the default parameter set
//   Optional feature macro: SCHED_TIMEOUT_EN (SETTLE watchdog).
// ---------------------------------------------------------------------------
package wirelog_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    SETTLE = 2'd2,
    RESET  = 2'd3
  } sched_state_e;

  // Bits needed to count 0..n-1, but never a zero-width vector.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int MIN_SETTLE_DEF  = 2;
  localparam int TIMEOUT_CYC_DEF = 256;

`ifdef SCHED_TIMEOUT_EN
  localparam int CNT_W = clog2_min1(TIMEOUT_CYC_DEF);
`else
  localparam int CNT_W = clog2_min1(MIN_SETTLE_DEF);
`endif

endpackage

// File: rtl/wire_trigger_scheduler_if.sv
// ---------------------------------------------------------------------------
// wire_trigger_scheduler_if
//   Bundles the scheduler's source/network-facing signals.
//   master : trigger sources + wire network side (drives req, net_busy)
//   slave  : the scheduler itself
//   Signals:
//     req[NREQ]      per-source trigger request (level, sampled each clock)
//     net_busy       wire network still propagating
//     trig_valid     one-cycle launch pulse, trig_id qualifies it
//     trig_id[IDW]   launched source index
//     logic_reset    one-cycle frame-end pulse re-arming gates and latches
//     pending[NREQ]  registered pending-request vector
//     busy           scheduler is inside a frame
//     timeout_err    sticky watchdog flag (SCHED_TIMEOUT_EN builds only)
//     dbg_state      current FSM state, for observation only
//
//   Handshake: trig_valid is a push-only pulse with no ready; the network
//   cannot refuse a launch, it can only hold net_busy high to stretch the
//   settle phase. trig_id is meaningful only in the cycle trig_valid=1.
// ---------------------------------------------------------------------------
interface wire_trigger_scheduler_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]                req;
  logic                           net_busy;
  logic                           trig_valid;
  logic [IDW-1:0]                 trig_id;
  logic                           logic_reset;
  logic [NREQ-1:0]                pending;
  logic                           busy;
  logic                           timeout_err;
  wirelog_sched_pkg::sched_state_e dbg_state;

  modport master (
    output req, net_busy,
    input  trig_valid, trig_id, logic_reset, pending, busy, timeout_err, dbg_state
  );

  modport slave (
    input  req, net_busy,
    output trig_valid, trig_id, logic_reset, pending, busy, timeout_err, dbg_state
  );
endinterface

// File: rtl/wire_trigger_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick: the first set bit of i_pending searching
//   upward from i_rr_ptr+1, wrapping at NREQ-1 back to 0.
//   Ports:
//     i_pending[NREQ]       candidate requests
//     i_rr_ptr[IDW]         index of the previous winner
//     i_en                  enable; outputs are all zero when low
//     o_grant_onehot[NREQ]  winner as a one-hot vector
//     o_grant_id[IDW]       winner index
//     o_any                 a winner exists
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_pending,
  input  logic [IDW-1:0]  i_rr_ptr,
  input  logic            i_en,
  output logic [NREQ-1:0] o_grant_onehot,
  output logic [IDW-1:0]  o_grant_id,
  output logic            o_any
);

  always_comb begin : pick
    int   w_idx;
    logic w_found;
    w_idx          = 0;
    w_found        = 1'b0;
    o_grant_onehot = '0;
    o_grant_id     = '0;
    // Offsets 1..NREQ: the previous winner itself is considered last.
    for (int i = 1; i <= NREQ; i++) begin
      w_idx = (int'(i_rr_ptr) + i) % NREQ;
      if (i_en && !w_found && i_pending[w_idx]) begin
        w_found               = 1'b1;
        o_grant_id            = IDW'(w_idx);
        o_grant_onehot[w_idx] = 1'b1;
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/wire_trigger_scheduler.sv
// ---------------------------------------------------------------------------
// wire_trigger_scheduler
//   Serialises trigger events from NREQ sources onto the single wire network.
//   One source is granted per frame (round-robin); a frame is
//   IDLE -> LAUNCH (trig_valid) -> SETTLE (>= MIN_SETTLE cycles, then until
//   net_busy drops) -> RESET (logic_reset) -> IDLE.
//   Ports:
//     clk    system clock, all state on posedge
//     rst_n  asynchronous active-low reset
//     bus    wire_trigger_scheduler_if.slave (req, net_busy in; trig_valid,
//            trig_id, logic_reset, pending, busy, timeout_err, dbg_state out)
//   Optional feature macro: SCHED_TIMEOUT_EN -- SETTLE is forced to end after
//   TIMEOUT_CYC cycles and timeout_err latches until reset. Without it,
//   SETTLE waits on net_busy indefinitely and timeout_err is tied 0.
// ---------------------------------------------------------------------------
module wire_trigger_scheduler
  import wirelog_sched_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int IDW         = $clog2(NREQ),
  parameter int MIN_SETTLE  = 2,
  parameter int TIMEOUT_CYC = 256
) (
  input logic                     clk,
  input logic                     rst_n,
  wire_trigger_scheduler_if.slave bus
);

`ifdef SCHED_TIMEOUT_EN
  localparam int SETTLE_W = (clog2_min1(TIMEOUT_CYC) > clog2_min1(MIN_SETTLE)) ?
                            clog2_min1(TIMEOUT_CYC) : clog2_min1(MIN_SETTLE);
`else
  localparam int SETTLE_W = clog2_min1(MIN_SETTLE);
`endif

  // Reject parameter sets the frame logic cannot honour.
  if (NREQ < 2 || NREQ > 32) begin : g_bad_nreq
    $error("wire_trigger_scheduler: NREQ must be 2..32");
  end
  if (IDW != $clog2(NREQ)) begin : g_bad_idw
    $error("wire_trigger_scheduler: IDW must equal $clog2(NREQ)");
  end
  if (MIN_SETTLE < 1 || TIMEOUT_CYC <= MIN_SETTLE) begin : g_bad_settle
    $error("wire_trigger_scheduler: need MIN_SETTLE >= 1 and TIMEOUT_CYC > MIN_SETTLE");
  end

  sched_state_e        r_state;
  logic                r_trig_valid;
  logic [IDW-1:0]      r_trig_id;
  logic                r_logic_reset;
  logic [IDW-1:0]      r_rr_ptr;
  logic [NREQ-1:0]     r_grant_oh;
  logic [NREQ-1:0]     r_pending;
  logic [SETTLE_W-1:0] r_settle_cnt;
  logic                r_timeout_err;

  logic [NREQ-1:0]     w_clr;
  logic [NREQ-1:0]     w_grant_oh;
  logic [IDW-1:0]      w_grant_id;
  logic                w_any;
  logic                w_arb_en;
  logic                w_min_done;

  assign w_arb_en   = (r_state == IDLE);
  assign w_clr      = (r_state == LAUNCH) ? r_grant_oh : '0;
  assign w_min_done = (r_settle_cnt >= SETTLE_W'(MIN_SETTLE - 1));

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .i_pending      (r_pending),
    .i_rr_ptr       (r_rr_ptr),
    .i_en           (w_arb_en),
    .o_grant_onehot (w_grant_oh),
    .o_grant_id     (w_grant_id),
    .o_any          (w_any)
  );

  // A request in the same cycle as its clear wins, so a source that keeps
  // asking is re-queued rather than dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pending <= '0;
    else        r_pending <= (r_pending & ~w_clr) | bus.req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_trig_valid  <= 1'b0;
      r_trig_id     <= '0;
      r_logic_reset <= 1'b0;
      r_rr_ptr      <= IDW'(NREQ - 1);  // source 0 wins the first frame
      r_grant_oh    <= '0;
      r_settle_cnt  <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_trig_valid  <= 1'b0;
      r_logic_reset <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state      <= LAUNCH;
            r_trig_valid <= 1'b1;
            r_trig_id    <= w_grant_id;
            r_grant_oh   <= w_grant_oh;
          end
        end
        LAUNCH: begin
          r_rr_ptr     <= r_trig_id;
          r_settle_cnt <= '0;
          r_state      <= SETTLE;
        end
        SETTLE: begin
          if (r_settle_cnt != '1) r_settle_cnt <= r_settle_cnt + SETTLE_W'(1);
          if (w_min_done && !bus.net_busy) begin
            r_state       <= RESET;
            r_logic_reset <= 1'b1;
          end
`ifdef SCHED_TIMEOUT_EN
          else if (r_settle_cnt >= SETTLE_W'(TIMEOUT_CYC - 1)) begin
            r_state       <= RESET;
            r_logic_reset <= 1'b1;
            r_timeout_err <= 1'b1;
          end
`endif
        end
        RESET:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.trig_valid  = r_trig_valid;
  assign bus.trig_id     = r_trig_id;
  assign bus.logic_reset = r_logic_reset;
  assign bus.pending     = r_pending;
  assign bus.busy        = (r_state != IDLE);
  assign bus.dbg_state   = r_state;
`ifdef SCHED_TIMEOUT_EN
  assign bus.timeout_err = r_timeout_err;
`else
  assign bus.timeout_err = 1'b0;
`endif

endmodule
